// File: rtl/decode_buffer.sv
// Decode buffer: circular queue of fetched instructions feeding up to DEC_W
// decode slots per cycle, with group termination on control flow and traps.
package decode_buffer_pkg;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        illegal;
    logic        is_term;
    logic        is_serial;
  } instr_info_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL      = 6'h00;
  localparam logic [5:0] F_SRL      = 6'h02;
  localparam logic [5:0] F_JR       = 6'h08;
  localparam logic [5:0] F_SYSCALL  = 6'h0C;
  localparam logic [5:0] F_ADDU     = 6'h21;
  localparam logic [5:0] F_SUBU     = 6'h23;
  localparam logic [5:0] F_OR       = 6'h25;
  localparam logic [5:0] F_XOR      = 6'h26;

  // Field split plus legality and group-boundary classification.
  function automatic instr_info_t decode(logic [31:0] ins);
    instr_info_t d;
    logic legal;
    logic term;
    logic serial;
    d.opcode = ins[31:26];
    d.rs     = ins[25:21];
    d.rt     = ins[20:16];
    d.rd     = ins[15:11];
    d.shamt  = ins[10:6];
    d.funct  = ins[5:0];
    d.imm    = ins[15:0];
    d.target = ins[25:0];
    legal    = 1'b0;
    term     = 1'b0;
    serial   = 1'b0;
    if (ins[31:26] == OP_SPECIAL) begin
      case (ins[5:0])
        F_ADDU, F_SUBU, F_OR, F_XOR, F_SLL, F_SRL: legal = 1'b1;
        F_JR: begin
          legal = 1'b1;
          term  = 1'b1;
        end
        F_SYSCALL: begin
          legal  = 1'b1;
          term   = 1'b1;
          serial = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (ins[31:26])
        OP_J, OP_JAL, OP_BEQ, OP_BNE: begin
          legal = 1'b1;
          term  = 1'b1;
        end
        OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
          legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
    d.illegal   = !legal;
    d.is_term   = term | !legal;
    d.is_serial = serial | !legal;
    return d;
  endfunction

endpackage

module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEC_W   = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_pc,
  input  logic [FETCH_W-1:0][31:0]       in_instr,
  input  logic [FETCH_W-1:0]             in_mask,
  output logic [DEC_W-1:0]               out_valid,
  output logic [DEC_W-1:0][31:0]         out_pc,
  output instr_info_t [DEC_W-1:0]        out_info,
  output logic [DEC_W-1:0]               out_illegal,
  input  logic [$clog2(DEC_W+1)-1:0]     deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DQ_W  = $clog2(DEC_W + 1);
  localparam int unsigned ENQ_W = $clog2(FETCH_W + 1);

  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      ins_mem [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DQ_W-1:0]  n_valid;
  logic [DQ_W-1:0]  deq_n;
  logic [ENQ_W-1:0] enq_n;
  logic             do_enq;

  // Slot i shows entry head+i; validity stops after the first group terminator.
  always_comb begin
    logic             term_seen;
    logic             v;
    logic [PTR_W-1:0] idx;
    instr_info_t      info;
    term_seen   = 1'b0;
    v           = 1'b0;
    idx         = '0;
    info        = '0;
    out_valid   = '0;
    out_pc      = '0;
    out_info    = '0;
    out_illegal = '0;
    n_valid     = '0;
    for (int unsigned i = 0; i < DEC_W; i++) begin
      idx            = head_q + PTR_W'(i);
      info           = decode(ins_mem[idx]);
      v              = (i < 32'(count_q)) && !term_seen && !((i != 0) && info.is_serial);
      out_pc[i]      = pc_mem[idx];
      out_info[i]    = info;
      out_valid[i]   = v;
      out_illegal[i] = v && info.illegal;
      term_seen      = term_seen | info.is_term;
      n_valid        = n_valid + DQ_W'(v);
    end
  end

  // Pointer and occupancy update; flush overrides enqueue and dequeue.
  always_comb begin
    enq_n = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      enq_n = enq_n + ENQ_W'(in_mask[i]);
    end
    in_ready = (32'(DEPTH) - 32'(count_q)) >= 32'(FETCH_W);
    do_enq   = in_valid && in_ready && (enq_n != '0);
    deq_n    = (deq_cnt < n_valid) ? deq_cnt : n_valid;
    head_d   = head_q + PTR_W'(deq_n);
    tail_d   = do_enq ? tail_q + PTR_W'(enq_n) : tail_q;
    count_d  = count_q + (do_enq ? CNT_W'(enq_n) : CNT_W'(0)) - CNT_W'(deq_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && in_valid && in_ready) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
        if (in_mask[i]) begin
          pc_mem[tail_q + PTR_W'(i)]  <= in_pc + 32'(4 * i);
          ins_mem[tail_q + PTR_W'(i)] <= in_instr[i];
        end
      end
    end
  end

  assign count = count_q;

endmodule
